logicnet_input_quantizer: RTL
=============================

Name: logicnet_input_quantizer

Overview:
- Front-end encoder for the generated LogicNet classifier; produces the packed 2-bit-per-feature input vector that the layer0 neuron LUTs consume.
- Accepts raw unsigned feature words serially over a valid/ready stream, one feature per beat.
- Quantizes each feature to a 2-bit code and packs a full frame of N_FEAT codes.
- Presents the packed frame to the network with a valid/ready handshake.

Parameters:
- N_FEAT, 32, features per frame; output width is 2*N_FEAT.
- IN_W, 16, raw feature width in bits, unsigned.
- ZP, 0, zero point subtracted before scaling; IN_W-bit unsigned.
- SHIFT, 12, right-shift applied after zero-point subtraction.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- s_valid  in  1  input feature valid
- s_ready  out  1  input feature accepted when s_valid && s_ready
- s_data  in  IN_W  raw feature value
- s_last  in  1  marks the final feature of a frame
- m_valid  out  1  packed frame valid
- m_ready  in  1  downstream (layer0) accepts frame
- m_data  out  2*N_FEAT  packed codes; feature k in bits [2k+1:2k], feature 0 at the LSBs
- err  out  1  sticky framing error
- frame_cnt  out  16  frames emitted (only with LNQ_FRAME_CNT_EN)

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values:
  - State FILL, idx=0.
  - s_ready=1 after reset deasserts.
  - m_valid=0, m_data=0, err=0, frame_cnt=0.
  - Reset asserted mid-frame discards the partial frame with no output.
- Quantization, combinational on s_data:
  - d = s_data - ZP, computed in IN_W+1 bits signed.
  - If d<0, code=0.
  - Otherwise q = d >> SHIFT; code = (q>3) ? 3 : q[1:0].
- FSM state FILL:
  - s_ready=1, m_valid=0.
  - On accept, write code into slot idx of the shadow register.
  - If idx==N_FEAT-1: copy the full vector (including this code) to m_data, set m_valid, go to HOLD, set idx=0.
  - Otherwise idx++.
- FSM state HOLD:
  - s_ready=0; m_valid=1; m_data held stable.
  - On m_valid && m_ready, go to FILL next cycle (m_valid=0, s_ready=1).
  - There is one bubble cycle between frames.
- Latency: last feature accepted at edge T → m_valid high after edge T; frame observable in cycle T+1.
- Framing boundaries:
  - s_last with idx<N_FEAT-1 (early last):
    - Set err.
    - Discard the partial frame and reset idx=0; the shadow register need not be cleared.
    - Emit no frame.
  - idx==N_FEAT-1 accepted without s_last (missing last):
    - Set err.
    - Still emit the frame.
    - The next beat starts a new frame.
  - err stays set until rst.
- Shadow slots not yet written in a frame keep their stale values, but are always overwritten before emission.
- m_ready high while m_valid=0 is ignored.

Optional Feature:
- Macro: LNQ_FRAME_CNT_EN.
- Defined:
  - frame_cnt port present.
  - Increments by 1 on each m_valid && m_ready handshake; wraps 0xFFFF→0.
  - Reset to 0.
- Undefined:
  - Port absent.
  - No counter logic.
  - All other behaviour identical.

Decomposition:
- Shared package lnq_pkg:
  - State enum {FILL, HOLD}.
  - Localparam Q_W=2.
  - Function quantize(data, zp, shift) returning the 2-bit code.
- One natural sub-module: lnq_quant_cell, the combinational zero-point/shift/clamp.
  - Instantiated once, on the incoming stream.
  - Reusable by the bench reference model.

Test Plan:
- Basic frame: N_FEAT=4, ZP=0, SHIFT=12; stream 0x0000, 0x1000, 0x2FFF, 0xF000 with s_last on the 4th → m_data=8'b11_10_01_00, m_valid one cycle after the last accept; err=0.
- Zero point and clamp: ZP=0x0100, SHIFT=8; inputs 0x0050, 0x0100, 0x0300, 0xFFFF → codes 0, 0, 2, 3.
- Backpressure: hold m_ready=0 for 10 cycles after the frame → m_data stable, s_ready=0 throughout, s_valid beats not accepted; release m_ready → s_ready=1 next cycle.
- Early s_last on the 2nd beat of a 4-feature frame → err=1, no m_valid; a following correct 4-beat frame is emitted with its own values only.
- Async reset pulse mid-frame after 2 beats → m_valid=0 and m_data=0 immediately; the next 4-beat frame packs correctly starting at feature 0.
- LNQ_FRAME_CNT_EN defined: 3 frames handshaked → frame_cnt=3; preload to 0xFFFF via 65535 frames (or a force) plus one more → 0.

Source files
------------

// File: rtl/lnq_pkg.sv
// Shared types and the zero-point/shift/clamp quantizer used by logicnet_input_quantizer.
package lnq_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } lnq_state_e;

    localparam int Q_W = 2;

    // Inputs are zero-extended to 32 bits so one function serves any IN_W <= 32.
    function automatic logic [Q_W-1:0] quantize(input logic [31:0] data,
                                                input logic [31:0] zp,
                                                input int unsigned shift);
        logic signed [32:0] d;
        logic        [32:0] q;
        d = $signed({1'b0, data}) - $signed({1'b0, zp});
        if (d < 0) begin
            return '0;
        end
        q = $unsigned(d) >> shift;
        if (q > 33'd3) begin
            return Q_W'(3);
        end
        return q[Q_W-1:0];
    endfunction

endpackage

// File: rtl/lnq_quant_cell.sv
// Combinational quantizer cell: raw feature word to 2-bit code.
// Zero latency; no flow control of its own.
module lnq_quant_cell
    import lnq_pkg::*;
#(
    parameter int          IN_W  = 16,
    parameter int unsigned ZP    = 0,
    parameter int unsigned SHIFT = 12
) (
    input  logic [IN_W-1:0] data_i,
    output logic [Q_W-1:0]  code_o
);

    assign code_o = quantize(32'(data_i), 32'(ZP), SHIFT);

endmodule

// File: rtl/logicnet_input_quantizer.sv
// Serial feature stream to packed 2-bit-per-feature frame for the layer0 LUTs.
// Frame valid the cycle after the last beat; input stalls while a frame is held. Optional LNQ_FRAME_CNT_EN adds frame_cnt.
module logicnet_input_quantizer
    import lnq_pkg::*;
#(
    parameter int          N_FEAT = 32,
    parameter int          IN_W   = 16,
    parameter int unsigned ZP     = 0,
    parameter int unsigned SHIFT  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [IN_W-1:0]       s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [Q_W*N_FEAT-1:0] m_data,
`ifdef LNQ_FRAME_CNT_EN
    output logic [15:0]           frame_cnt,
`endif
    output logic                  err
);

    localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int V_W   = Q_W * N_FEAT;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

    lnq_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [V_W-1:0]   shadow_q, shadow_d;
    logic [V_W-1:0]   mdata_q, mdata_d;
    logic             err_q, err_d;
    logic [Q_W-1:0]   code;

    lnq_quant_cell #(
        .IN_W (IN_W),
        .ZP   (ZP),
        .SHIFT(SHIFT)
    ) u_quant (
        .data_i(s_data),
        .code_o(code)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        mdata_d  = mdata_q;
        err_d    = err_q;
        s_ready  = 1'b0;
        m_valid  = 1'b0;
        unique case (state_q)
            FILL: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    shadow_d[int'(idx_q)*Q_W +: Q_W] = code;
                    if (idx_q == LAST_IDX) begin
                        // A missing s_last is flagged, but the full frame is still delivered.
                        mdata_d = shadow_d;
                        state_d = HOLD;
                        idx_d   = '0;
                        if (!s_last) begin
                            err_d = 1'b1;
                        end
                    end else if (s_last) begin
                        err_d = 1'b1;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FILL;
            idx_q    <= '0;
            shadow_q <= '0;
            mdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            mdata_q  <= mdata_d;
            err_q    <= err_d;
        end
    end

    assign m_data = mdata_q;
    assign err    = err_q;

`ifdef LNQ_FRAME_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (m_valid && m_ready) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign frame_cnt = cnt_q;
`endif

endmodule
